pipe_control_unit: RTL and testbench

- Pipelined successor to the combinational decoder: decodes the instruction latched in its own IF/ID register and carries control signals through the EX, MEM and WB stage registers.
- Detects load-use hazards and generates the stall, inserts bubbles on flush, and flags undefined encodings.
- Keeps saturating stall and flush performance counters.
- Sits between the fetch unit and the datapath of the 5-stage CPU.

---
 rtl/pipe_control_unit.sv | 129 ++++++++++++
 tb/tb_pipe_control_unit.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_control_unit.sv
// pipe_control_unit: decodes the IF/ID instruction, carries control words down EX/MEM/WB,
// generates load-use stalls, flush bubbles, illegal-encoding flag and saturating perf counters.
module pipe_control_unit #(
   parameter int WORD_SIZE = 16,
   parameter int REG_W     = 2,
   parameter int SIG_SIZE  = 16,
   parameter int CNT_W     = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 if_valid,
   input  logic [WORD_SIZE-1:0] if_instr,
   input  logic                 flush,
   output logic                 stall,
   output logic                 illegal,
   output logic [SIG_SIZE-1:0]  id_sig,
   output logic [SIG_SIZE-1:0]  ex_sig,
   output logic [SIG_SIZE-1:0]  mem_sig,
   output logic [SIG_SIZE-1:0]  wb_sig,
   output logic [REG_W-1:0]     ex_rd,
   output logic [REG_W-1:0]     mem_rd,
   output logic [REG_W-1:0]     wb_rd,
   output logic [CNT_W-1:0]     stall_cnt,
   output logic [CNT_W-1:0]     flush_cnt
);
   localparam int RS_MSB = WORD_SIZE - 5;
   localparam int RT_MSB = RS_MSB - REG_W;
   localparam int RD_MSB = RT_MSB - REG_W;
   logic                 id_v_q, id_v_d;
   logic [WORD_SIZE-1:0] id_instr_q, id_instr_d;
   logic [SIG_SIZE-1:0]  ex_sig_q, ex_sig_d, mem_sig_q, mem_sig_d, wb_sig_q, wb_sig_d;
   logic [REG_W-1:0]     ex_rd_q, ex_rd_d, mem_rd_q, mem_rd_d, wb_rd_q, wb_rd_d;
   logic                 ex_wr_q, ex_wr_d;
   logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
   logic [3:0]           op;
   logic [5:0]           func;
   logic [REG_W-1:0]     rs, rt, rd, dec_rd;
   logic [19:0]          ent;
   logic                 undef, use_rs, use_rt, hazard, kill_ex;
   logic [1:0]           dst;
   assign op   = id_instr_q[WORD_SIZE-1 -: 4];
   assign rs   = id_instr_q[RS_MSB -: REG_W];
   assign rt   = id_instr_q[RT_MSB -: REG_W];
   assign rd   = id_instr_q[RD_MSB -: REG_W];
   assign func = id_instr_q[5:0];
   // ent = {control word, uses rs, uses rt, dest select (0 none, 1 rt, 2 rd)}
   always_comb begin
      ent   = '0;
      undef = 1'b0;
      case ({op, op == 4'hf ? func : 6'h00})
         {4'hf, 6'h00}: ent = {16'h0810, 2'b11, 2'd2};
         {4'hf, 6'h01}: ent = {16'h0811, 2'b11, 2'd2};
         {4'hf, 6'h02}: ent = {16'h0815, 2'b11, 2'd2};
         {4'hf, 6'h03}: ent = {16'h0816, 2'b11, 2'd2};
         {4'hf, 6'h04}: ent = {16'h0819, 2'b10, 2'd2};
         {4'hf, 6'h05}: ent = {16'h081c, 2'b10, 2'd2};
         {4'hf, 6'h06}: ent = {16'h081d, 2'b10, 2'd2};
         {4'hf, 6'h07}: ent = {16'h081a, 2'b10, 2'd2};
         {4'hf, 6'h3f}: ent = '0;
         {4'h0, 6'h00}: ent = {16'h0201, 2'b11, 2'd0};
         {4'h1, 6'h00}: ent = {16'h0201, 2'b11, 2'd0};
         {4'h4, 6'h00}: ent = {16'h0030, 2'b10, 2'd1};
         {4'h5, 6'h00}: ent = {16'h0036, 2'b10, 2'd1};
         {4'h6, 6'h00}: ent = {16'h103f, 2'b00, 2'd1};
         {4'h7, 6'h00}: ent = {16'h0960, 2'b10, 2'd1};
         {4'h8, 6'h00}: ent = {16'h0060, 2'b11, 2'd0};
         {4'h9, 6'h00}: ent = {16'h0400, 2'b00, 2'd0};
         default:       undef = 1'b1;
      endcase
   end
   assign use_rs  = ent[3];
   assign use_rt  = ent[2];
   assign dst     = ent[1:0];
   assign dec_rd  = dst == 2'd2 ? rd : dst == 2'd1 ? rt : '0;
   assign id_sig  = id_v_q ? SIG_SIZE'(ent[19:4]) : '0;
   assign illegal = id_v_q && undef;
   // the load's destination write is tracked by ex_wr_q since its control word lacks bit 4
   assign hazard  = ex_sig_q[8] && ex_wr_q && ((use_rs && rs == ex_rd_q) || (use_rt && rt == ex_rd_q));
   assign stall   = id_v_q && !flush && hazard;
   assign kill_ex = flush || stall;
   always_comb begin
      id_v_d      = flush ? 1'b0 : stall ? id_v_q : if_valid;
      id_instr_d  = flush ? '0 : stall ? id_instr_q : if_instr;
      ex_sig_d    = kill_ex ? '0 : id_sig;
      ex_rd_d     = kill_ex || !id_v_q ? '0 : dec_rd;
      ex_wr_d     = !kill_ex && id_v_q && dst != 2'd0;
      mem_sig_d   = ex_sig_q;
      mem_rd_d    = ex_rd_q;
      wb_sig_d    = mem_sig_q;
      wb_rd_d     = mem_rd_q;
      stall_cnt_d = stall_cnt_q + CNT_W'(stall && !(&stall_cnt_q));
      flush_cnt_d = flush_cnt_q + CNT_W'(flush && !(&flush_cnt_q));
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         id_v_q      <= 1'b0;
         id_instr_q  <= '0;
         ex_sig_q    <= '0;
         ex_rd_q     <= '0;
         ex_wr_q     <= 1'b0;
         mem_sig_q   <= '0;
         mem_rd_q    <= '0;
         wb_sig_q    <= '0;
         wb_rd_q     <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         id_v_q      <= id_v_d;
         id_instr_q  <= id_instr_d;
         ex_sig_q    <= ex_sig_d;
         ex_rd_q     <= ex_rd_d;
         ex_wr_q     <= ex_wr_d;
         mem_sig_q   <= mem_sig_d;
         mem_rd_q    <= mem_rd_d;
         wb_sig_q    <= wb_sig_d;
         wb_rd_q     <= wb_rd_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end
   assign ex_sig    = ex_sig_q;
   assign mem_sig   = mem_sig_q;
   assign wb_sig    = wb_sig_q;
   assign ex_rd     = ex_rd_q;
   assign mem_rd    = mem_rd_q;
   assign wb_rd     = wb_rd_q;
   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_pipe_control_unit.sv
// tb_pipe_control_unit: vector table with a writeback scoreboard, plus hand sequences for
// reset, latency, load-use stall, flush and counter saturation.
module tb_pipe_control_unit;
   logic        clk = 1'b0;
   logic        reset, if_valid, flush;
   logic [15:0] if_instr;
   logic        stall, illegal, s_stall, s_illegal;
   logic [15:0] id_sig, ex_sig, mem_sig, wb_sig, s_id_sig, s_ex_sig, s_mem_sig, s_wb_sig;
   logic [1:0]  ex_rd, mem_rd, wb_rd, s_ex_rd, s_mem_rd, s_wb_rd;
   logic [15:0] stall_cnt, flush_cnt;
   logic [1:0]  s_stall_cnt, s_flush_cnt;
   int          total = 0, bad = 0;
   int          es = 0;
   typedef struct {
      logic        v;
      logic [15:0] instr;
      logic [15:0] sig;
      logic        ill;
      logic [1:0]  rd;
   } vec_t;
   vec_t        tbl[22];
   logic [17:0] sb[$];
   logic [17:0] exp_wb;

   pipe_control_unit dut (
      .clk(clk), .reset(reset), .if_valid(if_valid), .if_instr(if_instr), .flush(flush),
      .stall(stall), .illegal(illegal), .id_sig(id_sig), .ex_sig(ex_sig), .mem_sig(mem_sig),
      .wb_sig(wb_sig), .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );
   pipe_control_unit #(.CNT_W(2)) dut_s (
      .clk(clk), .reset(reset), .if_valid(if_valid), .if_instr(if_instr), .flush(flush),
      .stall(s_stall), .illegal(s_illegal), .id_sig(s_id_sig), .ex_sig(s_ex_sig), .mem_sig(s_mem_sig),
      .wb_sig(s_wb_sig), .ex_rd(s_ex_rd), .mem_rd(s_mem_rd), .wb_rd(s_wb_rd),
      .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [15:0] mk(input logic [3:0] op, input logic [1:0] rs, rt, rd,
                                      input logic [5:0] fn);
      return {op, rs, rt, rd, fn};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [15:0] ins);
      if_valid = v;
      if_instr = ins;
   endtask

   task automatic chk_zero(input string name);
      chk(name, {stall, illegal, id_sig, ex_sig, mem_sig, wb_sig, ex_rd, mem_rd, wb_rd}, 64'h0);
      chk({name, "_cnt"}, {stall_cnt, flush_cnt, s_stall_cnt, s_flush_cnt}, 64'h0);
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0;
      drive(1'b1, mk(4'hf, 2'd1, 2'd2, 2'd2, 6'h00));
      // reset: two cycles with a valid instruction presented
      tick(); chk_zero("rst_c1");
      tick(); chk_zero("rst_c2");
      reset = 1'b0; #1;
      chk_zero("rst_after");
      // straight-line ADD, rd=2
      drive(1'b1, mk(4'hf, 2'd0, 2'd1, 2'd2, 6'h00));
      tick(); chk("add_id", id_sig, 16'h0810);
      drive(1'b0, 16'h0);
      tick(); chk("add_ex", {ex_sig, ex_rd}, {16'h0810, 2'd2});
      chk("add_id_gone", id_sig, 16'h0);
      tick(); chk("add_mem", {mem_sig, mem_rd}, {16'h0810, 2'd2});
      tick(); chk("add_wb", {wb_sig, wb_rd}, {16'h0810, 2'd2});
      // load-use: LWD rt=1 then ADD rs=1
      drive(1'b1, mk(4'h7, 2'd0, 2'd1, 2'd0, 6'h04)); tick();
      drive(1'b1, mk(4'hf, 2'd1, 2'd0, 2'd3, 6'h00)); tick();
      chk("lu_ex_lwd", {ex_sig, ex_rd}, {16'h0960, 2'd1});
      chk("lu_stall", stall, 1'b1);
      drive(1'b0, 16'h0); tick(); es++;
      chk("lu_hold", {stall, id_sig, ex_sig}, {1'b0, 16'h0810, 16'h0000});
      chk("lu_mem", mem_sig, 16'h0960);
      chk("lu_cnt", stall_cnt, 16'(es));
      tick(); chk("lu_ex_add", {ex_sig, ex_rd}, {16'h0810, 2'd3});
      // no false stalls
      drive(1'b1, mk(4'h7, 2'd0, 2'd1, 2'd0, 6'h00)); tick();
      drive(1'b1, mk(4'hf, 2'd2, 2'd0, 2'd1, 6'h04)); tick();
      chk("nf_not", stall, 1'b0);
      drive(1'b1, mk(4'h7, 2'd0, 2'd1, 2'd0, 6'h00)); tick();
      drive(1'b1, mk(4'h6, 2'd0, 2'd1, 2'd0, 6'h12)); tick();
      chk("nf_lhi", stall, 1'b0);
      drive(1'b1, mk(4'h7, 2'd0, 2'd1, 2'd0, 6'h00)); tick();
      drive(1'b0, mk(4'hf, 2'd1, 2'd1, 2'd1, 6'h00)); tick();
      chk("nf_invalid", stall, 1'b0);
      // rt-side hazard through SWD
      drive(1'b1, mk(4'h7, 2'd0, 2'd1, 2'd0, 6'h00)); tick();
      drive(1'b1, mk(4'h8, 2'd0, 2'd1, 2'd0, 6'h00)); tick();
      chk("swd_stall", stall, 1'b1);
      drive(1'b0, 16'h0); tick(); es++;
      chk("swd_cnt", {stall, stall_cnt}, {1'b0, 16'(es)});
      tick();
      // flush with BEQ in EX and ADI in ID
      drive(1'b1, mk(4'h1, 2'd0, 2'd0, 2'd0, 6'h02)); tick();
      drive(1'b1, mk(4'h4, 2'd1, 2'd2, 2'd0, 6'h01)); tick();
      chk("fl_pre", {id_sig, ex_sig}, {16'h0030, 16'h0201});
      flush = 1'b1;
      drive(1'b1, mk(4'hf, 2'd0, 2'd0, 2'd1, 6'h00)); tick();
      flush = 1'b0;
      chk("fl_bubbles", {id_sig, ex_sig, mem_sig}, {16'h0, 16'h0, 16'h0201});
      chk("fl_cnt", flush_cnt, 16'd1);
      // flush together with a load-use condition
      drive(1'b1, mk(4'h7, 2'd0, 2'd1, 2'd0, 6'h00)); tick();
      drive(1'b1, mk(4'hf, 2'd1, 2'd0, 2'd3, 6'h00)); tick();
      flush = 1'b1; #1;
      chk("fl_lu_stall", stall, 1'b0);
      drive(1'b0, 16'h0); tick();
      flush = 1'b0;
      chk("fl_lu_cnts", {stall_cnt, flush_cnt}, {16'(es), 16'd2});
      chk("fl_lu_bub", {id_sig, ex_sig, mem_sig}, {16'h0, 16'h0, 16'h0960});
      // decode table through to writeback
      tbl[0]  = '{1'b1, mk(4'hf, 2'd1, 2'd2, 2'd3, 6'h00), 16'h0810, 1'b0, 2'd3};
      tbl[1]  = '{1'b1, mk(4'hf, 2'd0, 2'd1, 2'd2, 6'h01), 16'h0811, 1'b0, 2'd2};
      tbl[2]  = '{1'b1, mk(4'hf, 2'd3, 2'd3, 2'd1, 6'h02), 16'h0815, 1'b0, 2'd1};
      tbl[3]  = '{1'b1, mk(4'hf, 2'd2, 2'd1, 2'd0, 6'h03), 16'h0816, 1'b0, 2'd0};
      tbl[4]  = '{1'b1, mk(4'hf, 2'd1, 2'd0, 2'd3, 6'h04), 16'h0819, 1'b0, 2'd3};
      tbl[5]  = '{1'b1, mk(4'hf, 2'd2, 2'd0, 2'd1, 6'h05), 16'h081c, 1'b0, 2'd1};
      tbl[6]  = '{1'b1, mk(4'hf, 2'd3, 2'd0, 2'd2, 6'h06), 16'h081d, 1'b0, 2'd2};
      tbl[7]  = '{1'b1, mk(4'hf, 2'd0, 2'd0, 2'd3, 6'h07), 16'h081a, 1'b0, 2'd3};
      tbl[8]  = '{1'b1, mk(4'h4, 2'd1, 2'd2, 2'd1, 6'h05), 16'h0030, 1'b0, 2'd2};
      tbl[9]  = '{1'b1, mk(4'h5, 2'd0, 2'd3, 2'd2, 6'h11), 16'h0036, 1'b0, 2'd3};
      tbl[10] = '{1'b1, mk(4'h6, 2'd0, 2'd1, 2'd3, 6'h2a), 16'h103f, 1'b0, 2'd1};
      tbl[11] = '{1'b1, mk(4'h7, 2'd2, 2'd3, 2'd0, 6'h01), 16'h0960, 1'b0, 2'd3};
      tbl[12] = '{1'b1, mk(4'h8, 2'd0, 2'd1, 2'd0, 6'h02), 16'h0060, 1'b0, 2'd0};
      tbl[13] = '{1'b1, mk(4'h0, 2'd1, 2'd2, 2'd1, 6'h03), 16'h0201, 1'b0, 2'd0};
      tbl[14] = '{1'b1, mk(4'h1, 2'd3, 2'd0, 2'd2, 6'h3f), 16'h0201, 1'b0, 2'd0};
      tbl[15] = '{1'b1, mk(4'h9, 2'd3, 2'd3, 2'd3, 6'h3f), 16'h0400, 1'b0, 2'd0};
      tbl[16] = '{1'b1, mk(4'hf, 2'd0, 2'd0, 2'd0, 6'h3f), 16'h0000, 1'b0, 2'd0};
      tbl[17] = '{1'b1, mk(4'hf, 2'd1, 2'd1, 2'd2, 6'h08), 16'h0000, 1'b1, 2'd0};
      tbl[18] = '{1'b1, mk(4'h2, 2'd1, 2'd2, 2'd3, 6'h00), 16'h0000, 1'b1, 2'd0};
      tbl[19] = '{1'b1, mk(4'ha, 2'd0, 2'd0, 2'd0, 6'h00), 16'h0000, 1'b1, 2'd0};
      tbl[20] = '{1'b0, mk(4'h2, 2'd1, 2'd2, 2'd3, 6'h00), 16'h0000, 1'b0, 2'd0};
      tbl[21] = '{1'b0, mk(4'hf, 2'd1, 2'd2, 2'd3, 6'h00), 16'h0000, 1'b0, 2'd0};
      reset = 1'b1; tick(); reset = 1'b0;
      for (int i = 0; i < 26; i++) begin
         if (i < 22) drive(tbl[i].v, tbl[i].instr);
         else drive(1'b0, 16'h0);
         tick();
         if (i < 22) begin
            chk($sformatf("tbl%0d_id", i), {id_sig, illegal, stall}, {tbl[i].sig, tbl[i].ill, 1'b0});
            sb.push_back({tbl[i].sig, tbl[i].rd});
         end else sb.push_back(18'h0);
         if (sb.size() == 4) begin
            exp_wb = sb.pop_front();
            chk($sformatf("tbl_wb_at%0d", i), {wb_sig, wb_rd}, exp_wb);
         end
      end
      // counter saturation on the 2-bit instance
      reset = 1'b1; tick(); reset = 1'b0;
      chk("sat_clr", {s_flush_cnt, flush_cnt}, 18'h0);
      flush = 1'b1;
      tick(); tick(); tick();
      chk("sat_3", {s_flush_cnt, flush_cnt}, {2'd3, 16'd3});
      tick();
      flush = 1'b0;
      chk("sat_4", {s_flush_cnt, flush_cnt}, {2'd3, 16'd4});
      tick();
      chk("sat_hold", s_flush_cnt, 2'd3);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
